// File: rtl/core8_debug_mon_access.sv
// Debug monitor memory-access engine: turns JTAG ocimem commands into single-word
// Avalon-MM reads and writes, and reports data, ready and error back to the wrapper.
module core8_debug_mon_access #(
   parameter int ADDR_W  = 24,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              mon_busy,
   output logic [ADDR_W+1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest
);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] mon_addr;
   logic [15:0]       wait_cnt;
   logic              load_addr, start_rd, start_wr, cmd_busy;
   logic              xfer_done, xfer_abort;
   logic              unused_jdo;

   assign unused_jdo     = ^jdo;
   assign avm_address    = {mon_addr, 2'b00};
   assign avm_byteenable = 4'hF;

   assign xfer_done  = (state != IDLE) && !avm_waitrequest;
   // Abort on the cycle the stall count reaches TIMEOUT, so the strobe is held TIMEOUT cycles.
   assign xfer_abort = (state != IDLE) && avm_waitrequest && (wait_cnt == TIMEOUT_LAST);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_n   = state;
      load_addr = 1'b0;
      start_rd  = 1'b0;
      start_wr  = 1'b0;
      cmd_busy  = 1'b0;
      unique case (state)
         IDLE: begin
            if (take_action_ocimem_a) begin
               load_addr = 1'b1;
               start_rd  = jdo[34];
            end else if (take_action_ocimem_b) begin
               start_wr  = 1'b1;
            end else if (take_no_action_ocimem_a) begin
               start_rd  = 1'b1;
            end
            if (start_rd) state_n = RD;
            else if (start_wr) state_n = WR;
         end
         RD, WR: begin
            cmd_busy = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
            if (xfer_done || xfer_abort) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         avm_read  <= 1'b0;
         avm_write <= 1'b0;
      end else begin
         state     <= state_n;
         avm_read  <= (state_n == RD);
         avm_write <= (state_n == WR);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mon_addr      <= '0;
         MonDReg       <= '0;
         avm_writedata <= '0;
         monitor_ready <= 1'b1;
         monitor_error <= 1'b0;
         mon_busy      <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         if (load_addr)
            mon_addr <= jdo[ADDR_W-1:0];
         else if (xfer_done)
            mon_addr <= mon_addr + ADDR_W'(1);

         if (start_wr) begin
            MonDReg       <= jdo[31:0];
            avm_writedata <= jdo[31:0];
         end else if (xfer_done && state == RD) begin
            MonDReg <= avm_readdata;
         end

         if (start_rd || start_wr) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            mon_busy      <= 1'b1;
         end else if (xfer_done || xfer_abort) begin
            monitor_ready <= 1'b1;
            mon_busy      <= 1'b0;
         end
         // A dropped command or a timeout leaves a sticky error until the next accepted command.
         if (cmd_busy || xfer_abort)
            monitor_error <= 1'b1;

         if (state == IDLE || xfer_done)
            wait_cnt <= '0;
         else if (avm_waitrequest)
            wait_cnt <= wait_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_core8_debug_mon_access.sv
// Self-checking bench for core8_debug_mon_access: directed scenarios then random
// transactions against a transaction-level model of the monitor.
module tb_core8_debug_mon_access;

   localparam int ADDR_W  = 24;
   localparam int TIMEOUT = 4;
   localparam int K_A = 0, K_B = 1, K_NA = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [37:0]       jdo;
   logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [31:0]       MonDReg;
   logic              monitor_ready, monitor_error, mon_busy;
   logic [ADDR_W+1:0] avm_address;
   logic              avm_read, avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;

   int n_vec = 0;
   int n_err = 0;

   // Transaction-level model state
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_dreg;
   logic              m_ready, m_error;

   core8_debug_mon_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .jdo(jdo),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
      .mon_busy(mon_busy), .avm_address(avm_address), .avm_read(avm_read),
      .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " read"},  64'(avm_read), 64'(0));
      check({tag, " write"}, 64'(avm_write), 64'(0));
      check({tag, " busy"},  64'(mon_busy), 64'(0));
      check({tag, " ready"}, 64'(monitor_ready), 64'(m_ready));
      check({tag, " error"}, 64'(monitor_error), 64'(m_error));
      check({tag, " dreg"},  64'(MonDReg), 64'(m_dreg));
      check({tag, " addr"},  64'(avm_address), 64'({m_addr, 2'b00}));
   endtask

   // One command; waits = stall cycles before completion (>= TIMEOUT aborts);
   // inject = strobe-cycle index at which a stray write command is pulsed (-1 = none).
   task automatic run_cmd(input string tag, input int kind, input logic [37:0] jv,
                          input int waits, input logic [31:0] rdata, input int inject);
      bit   xfer;
      int   cycles, exp_cycles;
      bit   injected;
      @(negedge clk);
      jdo = jv;
      take_action_ocimem_a    = (kind == K_A);
      take_action_ocimem_b    = (kind == K_B);
      take_no_action_ocimem_a = (kind == K_NA);
      xfer = !(kind == K_A && !jv[34]);
      if (kind == K_A) m_addr = jv[ADDR_W-1:0];
      if (kind == K_B) m_dreg = jv[31:0];
      if (xfer) begin m_ready = 1'b0; m_error = 1'b0; end
      @(negedge clk);
      take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
      cycles = 0; injected = 1'b0;
      while ((avm_read || avm_write) && cycles < 100) begin
         take_action_ocimem_b = 1'b0;
         check({tag, " rd strobe"}, 64'(avm_read), 64'(kind != K_B));
         check({tag, " wr strobe"}, 64'(avm_write), 64'(kind == K_B));
         check({tag, " xfer addr"}, 64'(avm_address), 64'({m_addr, 2'b00}));
         check({tag, " xfer busy"}, 64'(mon_busy), 64'(1));
         if (kind == K_B) check({tag, " wdata"}, 64'(avm_writedata), 64'(jv[31:0]));
         avm_waitrequest = (cycles < waits);
         avm_readdata    = rdata;
         if (cycles == inject) begin
            take_action_ocimem_b = 1'b1;
            jdo = 38'($urandom);
            injected = 1'b1;
         end
         cycles++;
         @(negedge clk);
      end
      take_action_ocimem_b = 1'b0;
      avm_waitrequest = 1'b0;
      exp_cycles = !xfer ? 0 : (waits >= TIMEOUT ? TIMEOUT : waits + 1);
      check({tag, " strobe cycles"}, 64'(cycles), 64'(exp_cycles));
      if (xfer) begin
         m_ready = 1'b1;
         if (waits >= TIMEOUT) m_error = 1'b1;
         else begin
            if (kind != K_B) m_dreg = rdata;
            m_addr = m_addr + 1'b1;
         end
         if (injected) m_error = 1'b1;
      end
      check_idle(tag);
   endtask

   initial begin
      reset_n = 1'b0;
      jdo = '0;
      take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
      avm_readdata = '0; avm_waitrequest = 1'b0;
      m_addr = '0; m_dreg = '0; m_ready = 1'b1; m_error = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("byteenable", 64'(avm_byteenable), 64'hF);
      reset_n = 1'b1;

      // 1: address load + read, zero wait
      run_cmd("t1", K_A, 38'h4_0000_0010, 0, 32'hDEAD_BEEF, -1);
      check("t1 next addr", 64'(avm_address), 64'h44);

      // 2: load 0x20 only, write with 3 stalls, then read-next at 0x84
      run_cmd("t2 load", K_A, 38'h0_0000_0020, 0, 32'h0, -1);
      run_cmd("t2 write", K_B, 38'h0_1234_5678, 3, 32'h0, -1);
      run_cmd("t2 read", K_NA, 38'h0, 0, 32'hCAFE_0001, -1);

      // 3: timeout with waitrequest stuck
      run_cmd("t3 timeout", K_NA, 38'h0, 50, 32'h5555_AAAA, -1);

      // 4: wrap-around
      run_cmd("t4 wrap", K_A, 38'h4_00FF_FFFF, 1, 32'h0BAD_F00D, -1);
      run_cmd("t4 next", K_NA, 38'h0, 0, 32'h7777_0000, -1);

      // 5: command while busy, then an accepted command clears the error
      run_cmd("t5 busy cmd", K_NA, 38'h0, 2, 32'h1357_9BDF, 1);
      run_cmd("t5 clear", K_NA, 38'h0, 0, 32'h2468_ACE0, -1);

      // 6: reset mid-transfer
      @(negedge clk);
      take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      take_no_action_ocimem_a = 1'b0;
      avm_waitrequest = 1'b1;
      check("t6 read up", 64'(avm_read), 64'(1));
      #2 reset_n = 1'b0;
      #1;
      m_addr = '0; m_dreg = '0; m_ready = 1'b1; m_error = 1'b0;
      check_idle("t6 reset");
      @(negedge clk);
      avm_waitrequest = 1'b0;
      reset_n = 1'b1;

      // Random transactions
      for (int i = 0; i < 60; i++) begin
         int          kind, waits, inject;
         logic [37:0] jv;
         kind   = int'($urandom_range(2, 0));
         jv     = {6'($urandom), 32'($urandom)};
         waits  = int'($urandom_range(5, 0));
         inject = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
         run_cmd("rand", kind, jv, waits, 32'($urandom), inject);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
